// File: rtl/step_controller.sv
// Step/run sequencer for the single-cycle MIPS core: turns a raw step button and a
// run switch into a one-cycle cpu_en, with PC breakpoint halt and a pulse counter.
module step_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RUN_DIV         = 4,
    parameter int PC_WIDTH        = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                step_btn,
    input  logic                run_sw,
    input  logic                bp_en,
    input  logic [PC_WIDTH-1:0] bp_addr,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                cpu_en,
    output logic                halted,
    output logic [1:0]          state_led,
    output logic [7:0]          step_count
);
    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        RUN  = 2'b10,
        BRK  = 2'b11
    } state_t;

    state_t        state;
    logic          sync1, btn_s, btn_db, btn_db_q;
    logic [DW-1:0] deb_cnt;
    logic [RW-1:0] div;
    logic          first_slot;
    logic          step_press;

    // A level change is accepted only after it has been seen DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1    <= 1'b0;
            btn_s    <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= step_btn;
            btn_s    <= sync1;
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db  <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign step_press = btn_db & ~btn_db_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cpu_en     <= 1'b0;
            step_count <= '0;
            div        <= '0;
            first_slot <= 1'b0;
        end else begin
            cpu_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_sw) begin
                        state      <= RUN;
                        div        <= '0;
                        first_slot <= 1'b1;
                    end else if (step_press) begin
                        state      <= STEP;
                        cpu_en     <= 1'b1;
                        step_count <= step_count + 8'd1;
                    end
                end
                STEP: state <= IDLE;
                RUN: begin
                    if (!run_sw) begin
                        state <= IDLE;
                    end else if (div == RW'(RUN_DIV - 1)) begin
                        div        <= '0;
                        first_slot <= 1'b0;
                        // The first slot after entering RUN never halts, so a
                        // resume from BREAK steps past the breakpoint.
                        if (bp_en && pc == bp_addr && !first_slot) begin
                            state <= BRK;
                        end else begin
                            cpu_en     <= 1'b1;
                            step_count <= step_count + 8'd1;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                BRK: begin
                    if (step_press) begin
                        state      <= STEP;
                        cpu_en     <= 1'b1;
                        step_count <= step_count + 8'd1;
                    end else if (!run_sw) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign halted    = (state == BRK);
    assign state_led = state;
endmodule

// File: tb/tb_step_controller.sv
// Scoreboard bench for step_controller: the driver predicts each cpu_en pulse
// (edge number, count, state) from the timing rules; a monitor checks every pulse.
module tb_step_controller;
    localparam int D  = 4;
    localparam int RD = 4;
    localparam int PW = 5;

    logic          clock = 1'b0;
    logic          reset, step_btn, run_sw, bp_en;
    logic [PW-1:0] bp_addr, pc;
    logic          cpu_en, halted;
    logic [1:0]    state_led;
    logic [7:0]    step_count;

    step_controller #(.DEBOUNCE_CYCLES(D), .RUN_DIV(RD), .PC_WIDTH(PW)) dut (
        .clock(clock), .reset(reset), .step_btn(step_btn), .run_sw(run_sw),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en),
        .halted(halted), .state_led(state_led), .step_count(step_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int       edge_no;
        int       cnt;
        bit [1:0] st;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   cnt_m = 0;  // model pulse count (mod 256)
    int   pc_m = 0;   // model processor PC (mod 32)

    always @(posedge clock) cyc <= cyc + 1;

    // The "processor": PC advances on every enabled edge.
    always @(posedge clock) begin
        if (reset) pc <= '0;
        else if (cpu_en) pc <= pc + 1'b1;
    end

    always @(negedge clock) begin
        if (cpu_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: cpu_en high after edge %0d, none expected", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.edge_no || step_count != e.cnt[7:0] || state_led != e.st) begin
                    failures++;
                    $display("FAIL pulse: got edge=%0d count=%0d state=%0d, want edge=%0d count=%0d state=%0d",
                             cyc, step_count, state_led, e.edge_no, e.cnt, e.st);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic push(input int edge_no, input bit [1:0] st);
        exp_t e;
        cnt_m = (cnt_m + 1) % 256;
        pc_m  = (pc_m + 1) % 32;
        e.edge_no = edge_no;
        e.cnt     = cnt_m;
        e.st      = st;
        sb.push_back(e);
    endtask

    task automatic drained(input string name);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    // Slots fall every RD edges after RUN entry at edge e0; they stop when run_sw is
    // last seen high (edge last) or at the first non-exempt slot matching the breakpoint.
    task automatic model_run(input int e0, input int last, input bit bpen, input int bp,
                             output bit broke);
        broke = 1'b0;
        for (int m = 1; e0 + RD * m <= last; m++) begin
            if (bpen && pc_m == bp && m > 1) begin
                broke = 1'b1;
                break;
            end
            push(e0 + RD * m, 2'b10);
        end
    endtask

    // Press held for h cycles from IDLE/BREAK: pulse D+3 edges after the last idle edge.
    task automatic press(input int h);
        int k;
        k = cyc;
        step_btn = 1'b1;
        push(k + 3 + D, 2'b01);
        tick(h);
        step_btn = 1'b0;
        tick(D + 4);
        chk("after_press_state", state_led, 0);
        chk("after_press_count", step_count, cnt_m);
        drained("press_drained");
    endtask

    task automatic glitch();
        for (int i = 0; i < 8; i++) begin
            step_btn = (i % 2 == 0);
            tick(1);
        end
        for (int i = 0; i < 4; i++) begin
            step_btn = 1'b1;
            tick($urandom_range(D - 1, 1));
            step_btn = 1'b0;
            tick($urandom_range(3, 1));
        end
        tick(D + 4);
        chk("glitch_count", step_count, cnt_m);
        drained("glitch_drained");
    endtask

    task automatic run(input int n, input bit bpen, input int bp, output bit broke);
        int k;
        k = cyc;
        bp_en   = bpen;
        bp_addr = PW'(bp);
        run_sw  = 1'b1;
        model_run(k + 1, k + n, bpen, bp, broke);
        tick(n);
        chk("run_state", state_led, broke ? 3 : 2);
        chk("run_halted", halted, broke ? 1 : 0);
        chk("run_count", step_count, cnt_m);
    endtask

    task automatic run_stop();
        run_sw = 1'b0;
        tick(2);
        chk("stop_state", state_led, 0);
        drained("run_drained");
    endtask

    initial begin
        bit broke;
        int k, n;
        reset = 1'b1; step_btn = 1'b0; run_sw = 1'b0; bp_en = 1'b0;
        bp_addr = '0;
        tick(3);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_halted", halted, 0);
        chk("rst_state", state_led, 0);
        chk("rst_count", step_count, 0);
        reset = 1'b0;
        tick(2);

        press(10);
        glitch();

        run(20, 1'b0, 0, broke);
        run_stop();

        // Breakpoint 3 ahead of the current PC, then resume with run_sw held.
        run(RD * 5 + 2, 1'b1, (pc_m + 3) % 32, broke);
        chk("bp_broke", broke, 1);
        k = cyc;
        step_btn = 1'b1;
        push(k + 3 + D, 2'b01);
        n = D + 6 + RD * 3;
        model_run(k + 5 + D, k + n, 1'b1, int'(bp_addr), broke);
        tick(D + 1);
        step_btn = 1'b0;
        tick(n - (D + 1));
        chk("resume_state", state_led, broke ? 3 : 2);
        chk("resume_count", step_count, cnt_m);
        run_stop();
        tick(D + 4);

        for (int it = 0; it < 6; it++) begin
            press($urandom_range(D + 8, D));
            run($urandom_range(30, 5), 1'b0, 0, broke);
            run_stop();
            run(RD * 9, 1'b1, (pc_m + $urandom_range(6, 0)) % 32, broke);
            run_stop();
            glitch();
        end

        // Reset arriving on a slot edge drops that pulse and clears everything.
        k = cyc;
        bp_en  = 1'b0;
        run_sw = 1'b1;
        push(k + 1 + RD, 2'b10);
        push(k + 1 + 2 * RD, 2'b10);
        tick(3 * RD);
        reset  = 1'b1;
        run_sw = 1'b0;
        tick(1);
        reset = 1'b0;
        cnt_m = 0;
        pc_m  = 0;
        chk("mid_rst_state", state_led, 0);
        chk("mid_rst_count", step_count, 0);
        chk("mid_rst_halted", halted, 0);
        drained("mid_rst_drained");
        tick(1);
        chk("mid_rst_cpu_en", cpu_en, 0);
        press(D + 2);

        tick(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/step_controller.md
# step_controller

Execution sequencer for the single-cycle MIPS core on the DE2 board. It converts a raw step push-button and a run switch into a one-cycle clock-enable `cpu_en` for the processor: single steps, or free-run at a divided rate. Free-run halts on a PC breakpoint. It also exposes state, halt status and an 8-bit executed-instruction count for the LED/7-segment front panel.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required to accept a button level change (board build: 500000); legal range ≥2.
- `RUN_DIV`, 4: clock cycles between `cpu_en` pulses in run mode; legal range ≥2.
- `PC_WIDTH`, 5: width of `pc` and `bp_addr`.

Ports:
- `clock` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `step_btn` in 1: raw asynchronous push-button level, 1 = pressed.
- `run_sw` in 1: level, 1 = free-run requested.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in `PC_WIDTH`: breakpoint PC.
- `pc` in `PC_WIDTH`: current processor PC.
- `cpu_en` out 1: registered; processor state advances on edges where it is 1.
- `halted` out 1: 1 while in BREAK.
- `state_led` out 2: current state encoding.
- `step_count` out 8: number of `cpu_en` pulses issued, modulo 256.

## Operation
- Input conditioning:
  - `step_btn` passes a 2-flop synchronizer, giving `btn_s`.
  - The debounce counter increments each cycle `btn_s != btn_db` and clears when they are equal.
  - When the counter is at `DEBOUNCE_CYCLES-1` and `btn_s` still differs, `btn_db <= btn_s` and the counter clears.
  - `step_press = btn_db & ~btn_db_q` (one cycle per accepted press). Releases produce nothing.
- FSM states: IDLE=00, STEP=01, RUN=10, BREAK=11. Transitions:
  - IDLE:
    - `run_sw` → RUN: clear `div`, set `first_slot`.
    - else `step_press` → STEP, with `cpu_en<=1`.
    - `run_sw` has priority over `step_press`.
  - STEP: lasts exactly one cycle, then → IDLE. All inputs are ignored in this state.
  - RUN:
    - If `run_sw`=0 → IDLE, `cpu_en<=0`, no pulse.
    - Else, at a slot (`div==RUN_DIV-1`): `div<=0` and `first_slot<=0`.
      - If `bp_en && pc==bp_addr && !first_slot` → BREAK, no pulse.
      - Else `cpu_en<=1`.
    - Otherwise `div<=div+1`.
    - `step_press` is ignored in RUN.
  - BREAK:
    - `step_press` → STEP, which executes the breakpointed instruction.
    - else `run_sw`=0 → IDLE.
    - `step_press` has priority. With `run_sw` still 1, STEP→IDLE→RUN resumes past the breakpoint, because the first slot is exempt.
- `cpu_en` is 1 for exactly one cycle per pulse. It is never high on two consecutive cycles in RUN.
- `step_count` increments on the same edge that sets `cpu_en<=1`, and wraps 255→0.
- `halted` = (state==BREAK). `state_led` = state.

## Timing
- Reset values: state IDLE, `cpu_en`=0, `halted`=0, `state_led`=00, `step_count`=0; synchronizer, `btn_db`, `btn_db_q`, debounce counter, `div` all 0; `first_slot`=0.
- Reset mid-operation: takes effect at the next edge. Any pending pulse is dropped and no `cpu_en` is issued on that edge.
- Button held through reset release: it is accepted as one new press after debounce.
- Step latency: first edge sampling `step_btn`=1 is edge 1.
  - `btn_db` rises at edge 2+`DEBOUNCE_CYCLES`.
  - STEP is entered and `cpu_en`=1 after edge 3+`DEBOUNCE_CYCLES`. With D=4 that is edge 7.
- Run cadence: RUN is entered at edge E.
  - `cpu_en` is high after edges E+`RUN_DIV`, E+2·`RUN_DIV`, and so on.
  - Pulse period is `RUN_DIV`, duty is one cycle.
- Breakpoint compare: uses `pc` as sampled at the slot edge. That `pc` is already the value after the previous pulse.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles on `btn_s` produce no press.

## Test plan
- Reset, then `step_btn` high for 10 cycles, then low (D=4) → exactly one `cpu_en` pulse, one cycle wide, at edge 7. `step_count`=1, `state_led` sequence 00→01→00.
- `step_btn` bounce 1,0,1,0 per cycle for 8 cycles, then low → no `cpu_en`, `step_count`=0.
- `run_sw`=1 for 20 cycles (RUN_DIV=4), `bp_en`=0 → pulses at E+4, 8, 12, 16, 20, `step_count`=5. Dropping `run_sw` → IDLE next edge with no further pulse.
- Free-run with the bench advancing `pc` by 1 per pulse from 0, `bp_en`=1, `bp_addr`=3 → pulses while `pc`=0,1,2. At the slot with `pc`=3: BREAK, `halted`=1, `state_led`=11, no pulse, `step_count`=3.
- From that BREAK with `run_sw` held 1, debounced press → STEP pulse (`step_count`=4, `pc`→4), then IDLE, then RUN. Run continues without re-halting.
- `reset` asserted in RUN on a slot cycle → no pulse on that edge. All outputs return to reset values, and `step_count` restarts from 0.
